reg4_write_arbiter: RTL

REG4_WRITE_ARBITER -- requirements
Module: reg4_write_arbiter

---
 rtl/reg4_arb_pkg.sv | 25 ++
 rtl/reg4_write_arbiter_if.sv | 36 +++
 rtl/reg4_write_arbiter_rr_pick.sv | 38 +++
 rtl/reg4_write_arbiter.sv | 136 +++++++++++++
 4 files changed

// File: rtl/reg4_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : reg4_arb_pkg
//  Brief    : Shared types and helpers for the round-robin register writer
//  Revision : 1.0 - initial release
// ============================================================================
package reg4_arb_pkg;

    // Arbitration FSM: grant in IDLE, commit in WRITE, clear Ack in DONE
    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_WRITE = 2'd1,
        ST_DONE  = 2'd2
    } arb_state_t;

    localparam int c_DEF_NREQ  = 4;
    localparam int c_DEF_WIDTH = 4;

    // Width of a requester index; never below one bit
    function automatic int idx_w(input int n);
        return (n < 2) ? 1 : $clog2(n);
    endfunction

endpackage : reg4_arb_pkg
`default_nettype wire

// File: rtl/reg4_write_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : reg4_write_arbiter_if
//  Brief    : Request/data/ack bundle between requesters and the arbiter
//  Revision : 1.0 - initial release
// ============================================================================
interface reg4_write_arbiter_if
    import reg4_arb_pkg::*;
#(
    parameter int NREQ  = c_DEF_NREQ,
    parameter int WIDTH = c_DEF_WIDTH
);
    localparam int IW = idx_w(NREQ);

    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] data;
    logic                  clr;
    logic [NREQ-1:0]       ack;
    logic [WIDTH-1:0]      q;
    logic [IW-1:0]         owner;
    logic                  busy;

    // Requester side
    modport master (
        output req, data, clr,
        input  ack, q, owner, busy
    );

    // Arbiter side
    modport slave (
        input  req, data, clr,
        output ack, q, owner, busy
    );

endinterface : reg4_write_arbiter_if
`default_nettype wire

// File: rtl/reg4_write_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module   : rr_pick
//  Brief    : Combinational round-robin picker; searches upward from the
//             pointer and wraps from NREQ-1 to 0
//  Revision : 1.0 - initial release
// ============================================================================
module rr_pick #(
    parameter int NREQ = 4,
    parameter int IW   = 2
) (
    input  wire logic [NREQ-1:0] i_req,
    input  wire logic [IW-1:0]   i_ptr,
    output logic      [NREQ-1:0] o_onehot,
    output logic      [IW-1:0]   o_idx,
    output logic                 o_valid
);

    int w_pos;

    // First set request at or after the pointer, in circular order
    always_comb begin
        o_onehot = '0;
        o_idx    = '0;
        o_valid  = 1'b0;
        w_pos    = 0;
        for (int k = 0; k < NREQ; k++) begin
            w_pos = (int'(i_ptr) + k) % NREQ;
            if (!o_valid && i_req[w_pos]) begin
                o_valid         = 1'b1;
                o_onehot[w_pos] = 1'b1;
                o_idx           = IW'(w_pos);
            end
        end
    end

endmodule : rr_pick
`default_nettype wire

// File: rtl/reg4_write_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : reg4_write_arbiter
//  Brief    : Round-robin arbiter granting NREQ requesters write access to a
//             shared WIDTH-bit register, one commit per three cycles
//  Revision : 1.0 - initial release
// ============================================================================
module reg4_write_arbiter
    import reg4_arb_pkg::*;
#(
    parameter int NREQ  = c_DEF_NREQ,
    parameter int WIDTH = c_DEF_WIDTH
) (
    input  wire logic            clk,
    input  wire logic            rst_n,
    reg4_write_arbiter_if.slave  bus
);

    localparam int IW = idx_w(NREQ);

    arb_state_t        r_state;
    logic [NREQ-1:0]   r_grant;
    logic [WIDTH-1:0]  r_q;
    logic [NREQ-1:0]   r_ack;
    logic [IW-1:0]     r_owner;
    logic [IW-1:0]     r_ptr;

    arb_state_t        w_state_nxt;
    logic [NREQ-1:0]   w_grant_nxt;
    logic [WIDTH-1:0]  w_q_nxt;
    logic [NREQ-1:0]   w_ack_nxt;
    logic [IW-1:0]     w_owner_nxt;
    logic [IW-1:0]     w_ptr_nxt;

    logic [NREQ-1:0]   w_pick_onehot;
    logic [IW-1:0]     w_pick_idx;
    logic              w_pick_valid;
    logic [IW-1:0]     w_gidx;
    logic              w_still_req;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (IW)
    ) u_rr_pick (
        .i_req    (bus.req),
        .i_ptr    (r_ptr),
        .o_onehot (w_pick_onehot),
        .o_idx    (w_pick_idx),
        .o_valid  (w_pick_valid)
    );

    // Index of the registered one-hot grant
    always_comb begin
        w_gidx = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (r_grant[i]) begin
                w_gidx = IW'(i);
            end
        end
    end

    assign w_still_req = |(bus.req & r_grant);

    // Next-state and datapath decisions; everything holds unless changed
    always_comb begin
        w_state_nxt = r_state;
        w_grant_nxt = r_grant;
        w_q_nxt     = r_q;
        w_ack_nxt   = r_ack;
        w_owner_nxt = r_owner;
        w_ptr_nxt   = r_ptr;
        case (r_state)
            ST_IDLE: begin
                if (bus.clr) begin
                    // Clear wins over arbitration and costs no grant
                    w_q_nxt = '0;
                end else if (w_pick_valid) begin
                    w_grant_nxt = w_pick_onehot;
                    w_state_nxt = ST_WRITE;
                end
            end
            ST_WRITE: begin
                if (w_still_req) begin
                    // Data is taken now, not when the grant was issued
                    w_q_nxt     = bus.data[w_gidx*WIDTH +: WIDTH];
                    w_ack_nxt   = r_grant;
                    w_owner_nxt = w_gidx;
                    w_ptr_nxt   = (w_gidx == IW'(NREQ-1)) ? '0 : IW'(w_gidx + 1'b1);
                    w_state_nxt = ST_DONE;
                end else begin
                    // Requester withdrew: abandon the grant silently
                    w_state_nxt = ST_IDLE;
                end
                w_grant_nxt = '0;
            end
            ST_DONE: begin
                w_ack_nxt   = '0;
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
                w_grant_nxt = '0;
                w_ack_nxt   = '0;
            end
        endcase
    end

    // State and datapath registers, cleared asynchronously
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_grant <= '0;
            r_q     <= '0;
            r_ack   <= '0;
            r_owner <= '0;
            r_ptr   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_grant <= w_grant_nxt;
            r_q     <= w_q_nxt;
            r_ack   <= w_ack_nxt;
            r_owner <= w_owner_nxt;
            r_ptr   <= w_ptr_nxt;
        end
    end

    // Outputs straight from registers; Busy is any non-IDLE state
    always_comb begin
        bus.ack   = r_ack;
        bus.q     = r_q;
        bus.owner = r_owner;
        bus.busy  = (r_state != ST_IDLE);
    end

endmodule : reg4_write_arbiter
`default_nettype wire
